// File: rtl/audio_pdm_out.sv
// audio_pdm_out: converts a stream of 32-bit signed audio samples into a
// first-order sigma-delta PDM bitstream. Samples are scaled and saturated to
// 16 bits and buffered in a 4-entry FIFO. Playback starts once PREFILL entries
// are queued, and one sample is consumed every PERIOD clocks.
//
// Ports:
//   clk_in          - clock, all logic on its rising edge
//   rst_in          - synchronous active-low reset
//   audio_in        - signed 32-bit input sample
//   audio_valid_in  - audio_in valid strobe (no backpressure)
//   pdm_out         - registered sigma-delta bitstream
//   sample_out      - signed 16-bit sample currently being modulated
//   sample_tick_out - one-cycle pulse after sample_out is reloaded from the FIFO
//   fifo_count_out  - FIFO occupancy, 0..4
//   overflow_out    - sticky: an input was dropped because the FIFO was full
//   underflow_out   - sticky: the FIFO was empty at a sample boundary
module audio_pdm_out #(
   parameter int unsigned SHIFT   = 8,
   parameter int unsigned PERIOD  = 2304,
   parameter int unsigned PREFILL = 2
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic [31:0] audio_in,
   input  logic        audio_valid_in,
   output logic        pdm_out,
   output logic [15:0] sample_out,
   output logic        sample_tick_out,
   output logic [2:0]  fifo_count_out,
   output logic        overflow_out,
   output logic        underflow_out
);

   localparam int unsigned CNT_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
   localparam int unsigned DEPTH = 4;

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_PLAY = 1'b1;

   logic [0:0]       r_state;
   logic [CNT_W-1:0] r_cnt;
   logic [2:0]       r_count;
   logic [1:0]       r_rd_ptr;
   logic [1:0]       r_wr_ptr;
   logic [15:0]      r_mem [DEPTH];
   logic [15:0]      r_sample;
   logic [15:0]      r_acc;
   logic             r_pdm;
   logic             r_tick;
   logic             r_overflow;
   logic             r_underflow;

   logic [0:0]         w_state_next;
   logic [CNT_W-1:0]   w_cnt_next;
   logic [2:0]         w_count_next;
   logic               w_boundary;
   logic               w_pop;
   logic               w_push;
   logic               w_drop;
   logic               w_underflow;
   logic signed [31:0] w_shifted;
   logic [15:0]        w_sat;
   logic [15:0]        w_u;
   logic [16:0]        w_acc_next;

   // Scale the incoming sample and clamp it into the signed 16-bit range.
   always_comb begin
      w_shifted = $signed(audio_in) >>> SHIFT;
      if (w_shifted > 32'sd32767) begin
         w_sat = 16'h7FFF;
      end else if (w_shifted < -32'sd32768) begin
         w_sat = 16'h8000;
      end else begin
         w_sat = w_shifted[15:0];
      end
   end

   // FIFO control, next state and period counter.
   always_comb begin
      w_state_next = r_state;
      w_cnt_next   = '0;
      w_boundary   = (r_state == ST_PLAY) && (r_cnt == CNT_W'(PERIOD - 1));
      // Occupancy is sampled before any same-cycle push, so an empty FIFO at a
      // boundary underflows even if a sample arrives in that very cycle.
      w_pop        = w_boundary && (r_count != 3'd0);
      w_underflow  = w_boundary && (r_count == 3'd0);
      // A full FIFO still accepts a push when a pop frees the head the same cycle.
      w_push       = audio_valid_in && ((r_count != 3'(DEPTH)) || w_pop);
      w_drop       = audio_valid_in && !w_push;
      w_count_next = r_count + 3'(w_push) - 3'(w_pop);

      case (r_state)
         ST_IDLE: begin
            if (w_count_next >= 3'(PREFILL)) begin
               w_state_next = ST_PLAY;
            end
         end
         ST_PLAY: begin
            if (w_underflow) begin
               w_state_next = ST_IDLE;
            end
         end
      endcase

      // Counter is zero in IDLE and on the first PLAY cycle, and wraps at the boundary.
      if ((r_state == ST_PLAY) && (w_state_next == ST_PLAY) && !w_boundary) begin
         w_cnt_next = r_cnt + CNT_W'(1);
      end
   end

   // First-order sigma-delta: offset-binary sample into a 16-bit accumulator;
   // the carry out is the PDM bit.
   always_comb begin
      w_u        = {~r_sample[15], r_sample[14:0]};
      w_acc_next = {1'b0, r_acc} + {1'b0, w_u};
   end

   // State, FIFO bookkeeping, held sample, flags and modulator.
   always_ff @(posedge clk_in) begin
      if (!rst_in) begin
         r_state     <= ST_IDLE;
         r_cnt       <= '0;
         r_count     <= '0;
         r_rd_ptr    <= '0;
         r_wr_ptr    <= '0;
         r_sample    <= '0;
         r_acc       <= '0;
         r_pdm       <= 1'b0;
         r_tick      <= 1'b0;
         r_overflow  <= 1'b0;
         r_underflow <= 1'b0;
      end else begin
         r_state <= w_state_next;
         r_cnt   <= w_cnt_next;
         r_count <= w_count_next;
         r_tick  <= w_pop;
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + 2'd1;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 2'd1;
            r_sample <= r_mem[r_rd_ptr];
         end else if (w_underflow) begin
            r_sample <= '0;
         end
         if (w_drop) begin
            r_overflow <= 1'b1;
         end
         if (w_underflow) begin
            r_underflow <= 1'b1;
         end
         r_acc <= w_acc_next[15:0];
         r_pdm <= w_acc_next[16];
      end
   end

   // Sample storage needs no reset; occupancy and pointers define validity.
   always_ff @(posedge clk_in) begin
      if (rst_in && w_push) begin
         r_mem[r_wr_ptr] <= w_sat;
      end
   end

   assign pdm_out         = r_pdm;
   assign sample_out      = r_sample;
   assign sample_tick_out = r_tick;
   assign fifo_count_out  = r_count;
   assign overflow_out    = r_overflow;
   assign underflow_out   = r_underflow;

endmodule

// File: doc/audio_pdm_out.md
AUDIO_PDM_OUT -- requirements
Module: audio_pdm_out

Interface
REQ-001 SHALL have parameter SHIFT, default 8: arithmetic right-shift applied to each 32-bit input sample.
REQ-002 SHALL have parameter PERIOD, default 2304: clocks per output sample.
REQ-003 SHALL have parameter PREFILL, default 2: FIFO entries required before playback starts; legal range 1..4.
REQ-004 SHALL have port clk_in, input, 1: the only clock; all logic on its rising edge.
REQ-005 SHALL have port rst_in, input, 1: synchronous, active-low reset (0 = reset).
REQ-006 SHALL have port audio_in, input, 32: signed PSOLA output sample from the playback buffer.
REQ-007 SHALL have port audio_valid_in, input, 1: audio_in is valid this cycle; single-cycle pulses, no backpressure.
REQ-008 SHALL have port pdm_out, output, 1: registered first-order sigma-delta bitstream.
REQ-009 SHALL have port sample_out, output, 16: signed sample currently held for modulation.
REQ-010 SHALL have port sample_tick_out, output, 1: one-cycle pulse after sample_out is reloaded.
REQ-011 SHALL have port fifo_count_out, output, 3: current FIFO occupancy, 0..4.
REQ-012 SHALL have port overflow_out, output, 1: sticky flag, input dropped because the FIFO was full.
REQ-013 SHALL have port underflow_out, output, 1: sticky flag, FIFO empty at a sample boundary.

Function
REQ-014 SHALL convert on push: s = audio_in >>> SHIFT (sign-preserving), then saturate to -32768..32767.
REQ-015 SHALL store converted samples in a 4-entry FIFO; a push occurs when audio_valid_in=1 and count<4.
REQ-016 SHALL drop the sample when audio_valid_in=1 and count=4 with no pop that cycle, and set overflow_out.
REQ-017 SHALL accept the push when a push and a pop coincide at count=4; count stays 4.
REQ-018 SHALL have two FSM states: IDLE (reset state) and PLAY.
REQ-019 In IDLE, the period counter SHALL be held at 0, sample_out SHALL be 0, and no pops SHALL occur.
REQ-020 SHALL go IDLE->PLAY on the edge where count (after any push that cycle) is >= PREFILL; the counter starts at 0 in the first PLAY cycle.
REQ-021 In PLAY, the counter SHALL increment every clock from 0 to PERIOD-1 and then wrap to 0; the wrap cycle is the boundary.
REQ-022 At a boundary with count>0, the FIFO head SHALL be popped into sample_out on that edge, and sample_tick_out SHALL be 1 in the next cycle only.
REQ-023 At a boundary with count=0 (sampled before a same-cycle push), the block SHALL set underflow_out, load sample_out=0, go to IDLE, pulse no tick, and still accept any same-cycle push.
REQ-024 Sigma-delta: u = sample_out with MSB inverted (offset binary, 16 bits); acc_next = {1'b0,acc[15:0]} + u (17 bits); acc <= acc_next and pdm_out <= acc_next[16] every cycle, in both states.
REQ-025 Long-run pdm_out density SHALL equal u/65536 within 1/65536.
REQ-026 Flags SHALL clear only on reset.

Reset
REQ-027 While rst_in=0 at a clock edge, the block SHALL force FSM=IDLE, counter=0, FIFO empty (fifo_count_out=0), sample_out=0, acc=0, pdm_out=0, sample_tick_out=0, overflow_out=0, underflow_out=0.
REQ-028 Reset asserted mid-PLAY SHALL discard FIFO contents; an audio_valid_in during reset SHALL be ignored.

Verification (PERIOD=16, SHIFT=8, PREFILL=2)
REQ-029 Push 0x00123400 then 0x00FFFF00 -> PLAY starts; the first boundary 16 clocks later gives sample_out=0x1234 and then a tick; the next boundary gives sample_out=0x7FFF (saturated).
REQ-030 Push 0xFF000000 -> sample_out=0x8000 (-32768), and pdm_out density is 0 over 256 cycles; in IDLE, density is 128/256 exactly.
REQ-031 Push 6 samples back-to-back from IDLE -> fifo_count_out=4, overflow_out=1, and the 5th and 6th values are never output.
REQ-032 Prefill 2 samples and supply no more -> after 2 ticks the third boundary sets underflow_out=1, sample_out=0, state IDLE; 2 further pushes restart PLAY.
REQ-033 Hold sample_out=0x4000 (u=0xC000) -> exactly 192 ones per 256 cycles after settle.
REQ-034 Drive rst_in=0 for 1 cycle mid-PLAY with count=3 -> all outputs return to reset values on the next edge, and playback resumes only after PREFILL new pushes.
